// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared address map and defaults for the memory/I/O responder.
package mem_io_responder_pkg;
   localparam int ADDR_WIDTH_DEF = 17;
   localparam logic [1:0] IO_SEL = 2'b11;
   localparam logic [17:0] IO_BASE = 18'h30000;
   localparam logic [17:0] IO_UART = 18'h30000;
   localparam logic [17:0] IO_CLK = 18'h30004;
endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with occupancy count; push and pop may coincide even when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head reads as zero when empty so consumers never see stale storage.
   assign dout = empty ? '0 : mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: bus target owning program RAM, UART FIFOs, cycle counter and program-stop flag.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        prog_stop
);
   localparam int TCW = $clog2(TX_DEPTH) + 1;
   localparam int RCW = $clog2(RX_DEPTH) + 1;
   logic [7:0] ram [2**ADDR_WIDTH];
   logic [17:0] a;
   logic io, ram_hit, tx_push, tx_empty, rx_pop, rx_full, rx_empty, snap_ld;
   logic [7:0] rd, tx_din, rx_dout;
   logic [31:0] cnt, snap;
   logic [TCW-1:0] tx_count;
   logic [RCW-1:0] rx_count_unused;
   logic tx_full_unused;
   logic unused_addr;
   assign a = mem_a[17:0];
   assign unused_addr = ^mem_a[31:18];
   assign io = a[17:16] == IO_SEL;
   assign ram_hit = !io && (a >> ADDR_WIDTH) == 18'd0;
   assign tx_push = mem_wr && ((a == IO_UART && mem_dout != 8'h00) || a == IO_CLK);
   assign tx_din = a == IO_CLK ? 8'h00 : mem_dout;
   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign io_buffer_full = tx_count >= TCW'(TX_DEPTH - 2);
   always_comb begin
      rd = 8'h00;
      rx_pop = 1'b0;
      snap_ld = 1'b0;
      if (!mem_wr) begin
         if (ram_hit) rd = ram[a[ADDR_WIDTH-1:0]];
         else if (a == IO_UART) begin
            rd = rx_dout;
            rx_pop = !rx_empty;
         end else if (a[17:2] == IO_CLK[17:2]) begin
            // Byte 0 latches the counter; bytes 1..3 read the frozen snapshot.
            snap_ld = a[1:0] == 2'd0;
            rd = snap_ld ? cnt[7:0] : snap[{a[1:0], 3'b000} +: 8];
         end
      end
   end
   always_ff @(posedge clk_in)
      if (mem_wr && ram_hit) ram[a[ADDR_WIDTH-1:0]] <= mem_dout;
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         mem_din <= 8'h00;
         cnt <= 32'd0;
         snap <= 32'd0;
         prog_stop <= 1'b0;
      end else begin
         mem_din <= rd;
         cnt <= cnt + 32'd1;
         if (snap_ld) snap <= cnt;
         if (mem_wr && a == IO_CLK) prog_stop <= 1'b1;
      end
   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
      .clk(clk_in), .rst(rst_in), .push(tx_push), .pop(tx_valid && tx_ready),
      .din(tx_din), .dout(tx_data), .full(tx_full_unused), .empty(tx_empty), .count(tx_count)
   );
   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
      .clk(clk_in), .rst(rst_in), .push(rx_valid && rx_ready), .pop(rx_pop),
      .din(rx_data), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count_unused)
   );
endmodule
